// File: rtl/stack_pkg.sv
// Shared types and defaults for the 16-bit-word hardware stack controller.
// The stack grows down from SP_INIT toward SP_LIMIT.
package stack_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUSH1 = 3'd1,
        S_PUSH2 = 3'd2,
        S_POP1  = 3'd3,
        S_POPD1 = 3'd4,
        S_POPD2 = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_t;

    localparam logic [31:0] SP_INIT_DEF  = 32'h000F_FFFF;
    localparam logic [31:0] SP_LIMIT_DEF = 32'h000F_F000;

    // Number of 16-bit stack words moved by one request.
    function automatic logic [31:0] word_count(input logic wide);
        return wide ? 32'd2 : 32'd1;
    endfunction

endpackage

// File: rtl/stack_bound_chk.sv
// Combinational legality check for a stack request against the current SP.
// Push needs enough free words above SP_LIMIT-1; pop needs enough live words below SP_INIT.
module stack_bound_chk
    import stack_pkg::*;
#(
    parameter logic [31:0] SP_INIT  = SP_INIT_DEF,
    parameter logic [31:0] SP_LIMIT = SP_LIMIT_DEF
) (
    input  logic [31:0] sp,
    input  logic        op,
    input  logic        wide,
    output logic        legal,
    output logic        ovf,
    output logic        unf
);

    logic [31:0] n;
    logic [31:0] room;
    logic [31:0] depth;
    logic        push_ok;
    logic        pop_ok;
    logic        is_pop;

    assign n     = word_count(wide);
    assign room  = sp - SP_LIMIT + 32'd1;
    assign depth = SP_INIT - sp;

    always_comb begin
        push_ok = (room >= n);
        pop_ok  = (depth >= n);
        is_pop  = (op_t'(op) == OP_POP);
        legal   = is_pop ? pop_ok : push_ok;
        ovf     = !is_pop && !push_ok;
        unf     = is_pop && !pop_ok;
    end

endmodule

// File: rtl/stack_ctrl.sv
// Hardware stack controller: pushes/pops 16- or 32-bit values through a 16-bit
// data-memory port, one word per cycle, with overflow/underflow rejection.
//
// state  | meaning
// IDLE   | ready for a request; legality decided at accept
// PUSH1  | write first word (high half if wide) at SP, SP decrements
// PUSH2  | write low half at SP, SP decrements
// POP1   | read SP+1, SP increments
// POPD1  | capture first word; wide issues second read at SP+1
// POPD2  | capture high half
// DONE   | one-cycle response, error flags if rejected
module stack_ctrl
    import stack_pkg::*;
#(
    parameter logic [31:0] SP_INIT  = SP_INIT_DEF,
    parameter logic [31:0] SP_LIMIT = SP_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic        req_wide,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic        mem_re,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        ovf,
    output logic        unf,
    output logic [31:0] sp_out
);

    state_t      state_q, state_d;
    logic [31:0] sp_q;
    op_t         op_q;
    logic        wide_q;
    logic [31:0] wdata_q;
    logic [15:0] lo_q;
    logic [31:0] rsp_q;
    logic        rej_q;

    logic        accept;
    logic        sp_inc;
    logic        sp_dec;
    logic        chk_legal;
    logic        chk_ovf;
    logic        chk_unf;

    stack_bound_chk #(
        .SP_INIT  (SP_INIT),
        .SP_LIMIT (SP_LIMIT)
    ) u_bound_chk (
        .sp    (sp_q),
        .op    (req_op),
        .wide  (req_wide),
        .legal (chk_legal),
        .ovf   (chk_ovf),
        .unf   (chk_unf)
    );

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == S_DONE);
    assign ovf       = rsp_valid && rej_q && (op_q == OP_PUSH);
    assign unf       = rsp_valid && rej_q && (op_q == OP_POP);
    assign rsp_data  = rsp_q;
    assign sp_out    = sp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 16'h0;
        sp_inc    = 1'b0;
        sp_dec    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!chk_legal) begin
                        state_d = S_DONE;
                    end else if (op_t'(req_op) == OP_POP) begin
                        state_d = S_POP1;
                    end else begin
                        state_d = S_PUSH1;
                    end
                end
            end
            S_PUSH1: begin
                mem_we    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = wide_q ? wdata_q[31:16] : wdata_q[15:0];
                sp_dec    = 1'b1;
                state_d   = wide_q ? S_PUSH2 : S_DONE;
            end
            S_PUSH2: begin
                mem_we    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = wdata_q[15:0];
                sp_dec    = 1'b1;
                state_d   = S_DONE;
            end
            S_POP1: begin
                mem_re   = 1'b1;
                mem_addr = sp_q + 32'd1;
                sp_inc   = 1'b1;
                state_d  = S_POPD1;
            end
            S_POPD1: begin
                if (wide_q) begin
                    mem_re   = 1'b1;
                    mem_addr = sp_q + 32'd1;
                    sp_inc   = 1'b1;
                    state_d  = S_POPD2;
                end else begin
                    state_d  = S_DONE;
                end
            end
            S_POPD2: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q    <= SP_INIT;
            op_q    <= OP_PUSH;
            wide_q  <= 1'b0;
            wdata_q <= 32'h0;
            rej_q   <= 1'b0;
        end else begin
            if (sp_dec) begin
                sp_q <= sp_q - 32'd1;
            end else if (sp_inc) begin
                sp_q <= sp_q + 32'd1;
            end
            if (accept) begin
                op_q    <= op_t'(req_op);
                wide_q  <= req_wide;
                wdata_q <= req_wdata;
                rej_q   <= chk_ovf || chk_unf;
            end
        end
    end

    // A wide pop stages its low half so rsp_data only changes when the pop completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_q  <= 16'h0;
            rsp_q <= 32'h0;
        end else begin
            if (accept && chk_unf) begin
                rsp_q <= 32'h0;
            end
            if (state_q == S_POPD1) begin
                if (wide_q) begin
                    lo_q <= mem_rdata;
                end else begin
                    rsp_q <= {16'h0, mem_rdata};
                end
            end
            if (state_q == S_POPD2) begin
                rsp_q <= {mem_rdata, lo_q};
            end
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: a word-stack model predicts every cycle's outputs,
// plus literal checks on memory contents, SP and response data.
module tb_stack_ctrl;

    localparam logic [31:0] INIT  = 32'h000F_FFFF;
    localparam logic [31:0] LIMIT = 32'h000F_FFFE;
    localparam int          CAP   = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic        req_wide;
    logic [31:0] req_wdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        ovf;
    logic        unf;
    logic [31:0] sp_out;

    stack_ctrl #(
        .SP_INIT  (INIT),
        .SP_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_wide  (req_wide),
        .req_wdata (req_wdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .ovf       (ovf),
        .unf       (unf),
        .sp_out    (sp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [15:0] wd;
        logic        rv;
        logic        ov;
        logic        un;
        logic        rdy;
        logic [31:0] rd;
        logic [31:0] sp;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] stk[$];
    logic [31:0] model_sp  = INIT;
    logic [31:0] model_rsp = 32'h0;
    logic [15:0] bmem [logic [31:0]];
    int          total = 0;
    int          bad   = 0;

    // Data memory: write on the edge, read data returned the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) bmem[mem_addr] = mem_wdata;
        if (mem_re) mem_rdata <= bmem.exists(mem_addr) ? bmem[mem_addr] : 16'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t base(input logic [31:0] rd, input logic [31:0] sp);
        exp_t e;
        e.we = 1'b0; e.re = 1'b0; e.addr = 32'h0; e.wd = 16'h0;
        e.rv = 1'b0; e.ov = 1'b0; e.un = 1'b0; e.rdy = 1'b0;
        e.rd = rd;   e.sp = sp;
        return e;
    endfunction

    // Queue the per-cycle outputs one request must produce, and update the stack model.
    task automatic plan(input logic op, input logic wide, input logic [31:0] wd, output int lat);
        int          n;
        exp_t        e;
        logic [31:0] sp0;
        logic [31:0] old;
        logic [15:0] words[2];
        logic [15:0] lo, hi;
        n   = wide ? 2 : 1;
        sp0 = model_sp;
        old = model_rsp;
        if (!op) begin
            if (stk.size() + n > CAP) begin
                e = base(old, sp0); e.rv = 1'b1; e.ov = 1'b1;
                exp_q.push_back(e);
                lat = 1;
            end else begin
                words[0] = wide ? wd[31:16] : wd[15:0];
                words[1] = wd[15:0];
                for (int k = 0; k < n; k++) begin
                    e = base(old, sp0 - 32'(k));
                    e.we = 1'b1; e.addr = sp0 - 32'(k); e.wd = words[k];
                    exp_q.push_back(e);
                    stk.push_back(words[k]);
                end
                e = base(old, sp0 - 32'(n)); e.rv = 1'b1;
                exp_q.push_back(e);
                lat = n + 1;
            end
        end else begin
            if (stk.size() < n) begin
                model_rsp = 32'h0;
                e = base(32'h0, sp0); e.rv = 1'b1; e.un = 1'b1;
                exp_q.push_back(e);
                lat = 1;
            end else begin
                for (int k = 0; k < n; k++) begin
                    e = base(old, sp0 + 32'(k));
                    e.re = 1'b1; e.addr = sp0 + 32'(k) + 32'd1;
                    exp_q.push_back(e);
                end
                exp_q.push_back(base(old, sp0 + 32'(n)));
                lo = stk.pop_back();
                hi = wide ? stk.pop_back() : 16'h0;
                model_rsp = {hi, lo};
                e = base(model_rsp, sp0 + 32'(n)); e.rv = 1'b1;
                exp_q.push_back(e);
                lat = n + 2;
            end
        end
        model_sp = INIT - 32'(stk.size());
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = base(model_rsp, model_sp);
                e.rdy = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(e.rdy));
            chk("mem_we",    32'(mem_we),    32'(e.we));
            chk("mem_re",    32'(mem_re),    32'(e.re));
            chk("mem_addr",  mem_addr,       e.addr);
            chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
            chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
            chk("ovf",       32'(ovf),       32'(e.ov));
            chk("unf",       32'(unf),       32'(e.un));
            chk("rsp_data",  rsp_data,       e.rd);
            chk("sp_out",    sp_out,         e.sp);
        end
    end

    task automatic do_req(input logic op, input logic wide, input logic [31:0] wd, input string name);
        int lat_exp;
        int k;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_wide = wide; req_wdata = wd;
        plan(op, wide, wd, lat_exp);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        k = 1;
        while (k <= 8 && !rsp_valid) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({name, " latency"}, 32'(k), 32'(lat_exp));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int lat;
        reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_wide = 1'b0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset sp_out",   sp_out, 32'h000F_FFFF);
        chk("reset ready",    32'(req_ready), 32'd1);
        chk("reset pulses",   32'({rsp_valid, ovf, unf, mem_we, mem_re}), 32'd0);
        chk("reset rsp_data", rsp_data, 32'h0);

        do_req(1'b1, 1'b0, 32'h0, "pop empty");
        chk("pop empty unf", 32'(unf), 32'd1);
        chk("pop empty sp",  sp_out, 32'h000F_FFFF);

        do_req(1'b0, 1'b1, 32'hDEAD_BEEF, "wide push");
        chk("wide push hi",  32'(bmem[32'h000F_FFFF]), 32'h0000_DEAD);
        chk("wide push lo",  32'(bmem[32'h000F_FFFE]), 32'h0000_BEEF);
        chk("wide push sp",  sp_out, 32'h000F_FFFD);

        do_req(1'b0, 1'b1, 32'h1234_5678, "wide push full");
        chk("wide push full ovf", 32'(ovf), 32'd1);
        do_req(1'b0, 1'b0, 32'h0000_7777, "narrow push full");

        do_req(1'b1, 1'b1, 32'h0, "wide pop");
        chk("wide pop data", rsp_data, 32'hDEAD_BEEF);
        chk("wide pop sp",   sp_out, 32'h000F_FFFF);

        do_req(1'b0, 1'b0, 32'h0000_1234, "narrow push");
        chk("narrow push sp", sp_out, 32'h000F_FFFE);
        do_req(1'b0, 1'b1, 32'hAAAA_5555, "wide push over");
        chk("wide push over ovf", 32'(ovf), 32'd1);
        chk("wide push over sp",  sp_out, 32'h000F_FFFE);

        do_req(1'b0, 1'b0, 32'hFFFF_ABCD, "narrow push 2");
        chk("push keeps rsp", rsp_data, 32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'h0, "narrow pop");
        chk("narrow pop data", rsp_data, 32'h0000_ABCD);
        do_req(1'b1, 1'b1, 32'h0, "wide pop short");
        chk("wide pop short unf",  32'(unf), 32'd1);
        chk("wide pop short data", rsp_data, 32'h0);
        do_req(1'b1, 1'b0, 32'h0, "narrow pop 2");
        chk("narrow pop 2 data", rsp_data, 32'h0000_1234);

        // Reset while the second word of a wide push is on the bus.
        bmem.delete();
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0; req_wide = 1'b1; req_wdata = 32'hDEAD_BEEF;
        plan(1'b0, 1'b1, 32'hDEAD_BEEF, lat);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        stk.delete();
        model_sp  = INIT;
        model_rsp = 32'h0;
        #1;
        chk("abort mem_we",    32'(mem_we), 32'd0);
        chk("abort sp",        sp_out, 32'h000F_FFFF);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort first write",     32'(bmem[32'h000F_FFFF]), 32'h0000_DEAD);
        chk("abort no second write", 32'(bmem.exists(32'h000F_FFFE)), 32'd0);

        do_req(1'b0, 1'b1, 32'hCAFE_F00D, "post reset push");
        do_req(1'b1, 1'b1, 32'h0, "post reset pop");
        chk("post reset pop data", rsp_data, 32'hCAFE_F00D);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter SP_INIT, 32'h000F_FFFF, stack pointer value after reset and top of stack region (stack grows down).
REQ-002 Parameter SP_LIMIT, 32'h000F_F000, lowest legal stack word address.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 req_valid  in  1  request present; req_ready  out  1  high only in IDLE.
REQ-006 req_op  in  1  0=push, 1=pop; req_wide  in  1  0=16-bit, 1=32-bit.
REQ-007 req_wdata  in  32  push data (low 16 bits only for narrow).
REQ-008 mem_addr  out  32, mem_we  out  1, mem_re  out  1, mem_wdata  out  16  data-memory port.
REQ-009 mem_rdata  in  16  read data, valid the cycle after mem_re.
REQ-010 rsp_valid  out  1  one-cycle completion pulse; rsp_data  out  32  pop result.
REQ-011 ovf  out  1, unf  out  1  error pulses coincident with rsp_valid; sp_out  out  32  current SP.

Function
REQ-012 Request accepted on rising edge with req_valid && req_ready; op, wide and wdata latched; req_valid ignored while req_ready low.
REQ-013 States: IDLE, PUSH1, PUSH2, POP1, POPD1, POPD2, DONE; one state per cycle, no waits.
REQ-014 Accept check: words n = wide ? 2 : 1; push legal iff (SP - SP_LIMIT + 1) >= n; pop legal iff (SP_INIT - SP) >= n; illegal -> IDLE to DONE directly, no memory access, SP unchanged.
REQ-015 PUSH1: mem_we=1, mem_addr=SP, mem_wdata = wide ? wdata[31:16] : wdata[15:0], SP<=SP-1; next PUSH2 if wide else DONE.
REQ-016 PUSH2: mem_we=1, mem_addr=SP, mem_wdata=wdata[15:0], SP<=SP-1; next DONE.
REQ-017 POP1: mem_re=1, mem_addr=SP+1, SP<=SP+1; next POPD1.
REQ-018 POPD1: capture mem_rdata; narrow -> rsp_data={16'h0,rdata}, next DONE; wide -> low half=rdata, mem_re=1, mem_addr=SP+1, SP<=SP+1, next POPD2.
REQ-019 POPD2: capture mem_rdata into rsp_data[31:16]; next DONE.
REQ-020 DONE: rsp_valid=1 one cycle; ovf=1 if push rejected, unf=1 if pop rejected (rsp_data=0 then); next IDLE.
REQ-021 Latency from accept edge T: narrow push rsp T+2, wide push T+3, narrow pop T+3, wide pop T+4, rejected T+1.
REQ-022 mem_we, mem_re low and mem_addr/mem_wdata zero in states not listed as driving them; never both high.
REQ-023 rsp_data holds last pop value until next pop completes; push does not modify it.
REQ-024 SP arithmetic 32-bit unsigned; bound checks guarantee SP stays within [SP_LIMIT-1, SP_INIT], no wrap.
REQ-025 sp_out equals registered SP every cycle.

Reset
REQ-026 On reset: SP=SP_INIT, state IDLE, rsp_data=0, rsp_valid/ovf/unf/mem_we/mem_re=0, req_ready=1 after release.
REQ-027 Reset mid-operation aborts sequence immediately; no further memory writes or reads issued, no rsp_valid.

Structure
REQ-028 Package stack_pkg holds state enum, op encoding (PUSH/POP), SP_INIT and SP_LIMIT defaults.
REQ-029 Sub-module stack_bound_chk (combinational: SP, op, wide -> legal, ovf/unf) instantiated once.

Verification
REQ-030 Reset -> sp_out=000F_FFFF, req_ready=1, all pulses 0.
REQ-031 Wide push DEADBEEF from reset -> write DEAD @000F_FFFF, BEEF @000F_FFFE, SP=000F_FFFD, rsp_valid at T+3.
REQ-032 Wide pop after REQ-031 -> reads @000F_FFFE then @000F_FFFF, rsp_data=DEADBEEF at T+4, SP=000F_FFFF.
REQ-033 Narrow pop from reset -> unf+rsp_valid at T+1, no mem_re, SP unchanged.
REQ-034 SP_LIMIT=000F_FFFE: narrow push 1234 ok (SP=000F_FFFE), then wide push -> ovf at T+1, no mem_we.
REQ-035 Reset asserted in PUSH2 of wide push -> no second write, SP=000F_FFFF, no rsp_valid.
